// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg
//   Shared definitions for the PCIe PHY transmit path: mode encodings,
//   state encodings for the width down-converter, and helpers that turn a
//   mode field into the number of bytes to serialise.
package pcie_phy_pkg;

    localparam logic [1:0] MODE_1B = 2'b00;
    localparam logic [1:0] MODE_2B = 2'b01;
    localparam logic [1:0] MODE_4B = 2'b10;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_STREAM = 1'b1
    } dc_state_t;

    // True when the mode asks for more bytes than the datapath carries.
    // Very large mode values are caught before the shift can overflow.
    function automatic logic mode_illegal(input int unsigned mode,
                                          input int unsigned max_bytes);
        if (mode >= 32'd31) return 1'b1;
        return ((32'd1 << mode) > max_bytes);
    endfunction

    // Active byte count for a mode, clamped to max_bytes for illegal modes.
    function automatic int unsigned bytes_for_mode(input int unsigned mode,
                                                   input int unsigned max_bytes);
        if (mode_illegal(mode, max_bytes)) return max_bytes;
        return (32'd1 << mode);
    endfunction

endpackage

// File: rtl/pcie_tx_width_downconv.sv
// pcie_tx_width_downconv
//   Serialises 1/2/4-byte words (with per-byte K flags) least-significant
//   byte first onto an 8-bit symbol stream, one byte per cycle, no bubble
//   between words.
//
// Ports
//   clk        rising-edge clock
//   reset_L    synchronous active-low reset
//   in_data    input word, byte i at [8i+7:8i]
//   in_k       K flag per input byte
//   in_mode    active width, bytes = 1 << in_mode (clamped to MAX_BYTES)
//   in_valid   input word valid
//   in_ready   block can accept a word this cycle
//   out_data   current output byte
//   out_k      K flag of current output byte
//   out_valid  out_data/out_k valid
//   out_ready  downstream accepts the byte this cycle
//   out_last   current byte is the last of its word
//   mode_err   one-cycle pulse after an illegal mode is accepted
//   busy       a word is being serialised (same as out_valid)
//
// Handshake: a transfer happens on a rising edge where valid && ready on
// the same side. valid never depends on ready; in_ready depends
// combinationally on out_ready so a new word can load on the edge that
// consumes the last byte of the current one.
module pcie_tx_width_downconv
    import pcie_phy_pkg::*;
#(
    parameter int MAX_BYTES = 4,
    parameter int MODE_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic [8*MAX_BYTES-1:0] in_data,
    input  logic [MAX_BYTES-1:0]   in_k,
    input  logic [MODE_W-1:0]      in_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_k,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   mode_err,
    output logic                   busy
);

    localparam int CNT_W = $clog2(MAX_BYTES) + 1;

    dc_state_t              state_q, state_d;
    logic [8*MAX_BYTES-1:0] sh_data_q;
    logic [MAX_BYTES-1:0]   sh_k_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   mode_err_q;

    logic accept;
    logic consume;

    // All outputs come straight from registers (or a compare on one),
    // so nothing on in_* reaches out_* within a cycle.
    assign out_valid = (state_q == ST_STREAM);
    assign busy      = out_valid;
    assign out_data  = sh_data_q[7:0];
    assign out_k     = sh_k_q[0];
    assign out_last  = (cnt_q == CNT_W'(1));
    assign mode_err  = mode_err_q;

    assign in_ready = reset_L && (!out_valid || (out_ready && out_last));
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:  if (accept) state_d = ST_STREAM;
            ST_STREAM: if (consume && out_last) state_d = accept ? ST_STREAM : ST_EMPTY;
            default:   state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q    <= ST_EMPTY;
            sh_data_q  <= '0;
            sh_k_q     <= '0;
            cnt_q      <= '0;
            mode_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Accept implies any current word is on its last byte and
                // being consumed, so the load simply replaces it.
                sh_data_q  <= in_data;
                sh_k_q     <= in_k;
                cnt_q      <= CNT_W'(bytes_for_mode(32'(in_mode), MAX_BYTES));
                mode_err_q <= mode_illegal(32'(in_mode), MAX_BYTES);
            end else begin
                mode_err_q <= 1'b0;
                if (consume) begin
                    sh_data_q <= sh_data_q >> 8;
                    sh_k_q    <= sh_k_q >> 1;
                    cnt_q     <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

endmodule
